// File: rtl/exe_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exe_seq_pkg
//  Purpose  : Shared types and constants for the sequential execution unit.
//             Holds the opcode encoding, the control FSM state encoding and
//             the bit positions of the packed 4-bit status flag vector.
//  Revision : 1.0  initial release
// ============================================================================
package exe_seq_pkg;

    // Opcode encoding. 4'hA..4'hF are all reserved; OP_RSVD names the first.
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_MUL  = 4'h8,
        OP_DIV  = 4'h9,
        OP_RSVD = 4'hA
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Packed flag vector layout: {NF, PF, BF1, BF0}.
    localparam int c_FLAG_BF0 = 0;
    localparam int c_FLAG_BF1 = 1;
    localparam int c_FLAG_PF  = 2;
    localparam int c_FLAG_NF  = 3;
    localparam int c_FLAG_W   = 4;

endpackage
`default_nettype wire

// File: rtl/exe_iter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : exe_iter_muldiv
//  Purpose  : Iterative M-step unsigned multiply (shift-add) and divide
//             (restoring). One step per cycle after i_start.
//  Ports    : i_clk, i_rst_n   clock, async active-low reset
//             i_start          load operands and begin (ignored operands
//                              afterwards)
//             i_is_div         1 = divide A/B, 0 = multiply A*B
//             i_a, i_b         operands
//             o_done           high in the cycle that performs the last step
//             o_result         value produced by the current step (valid with
//                              o_done): low product bits or quotient
//             o_ovf            multiply only: high product bits non-zero
//  Revision : 1.0  initial release
// ============================================================================
module exe_iter_muldiv #(
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_is_div,
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    output logic         o_done,
    output logic [M-1:0] o_result,
    output logic         o_ovf
);

    localparam int           c_CW   = $clog2(M);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(M - 1);

    logic            r_busy;
    logic            r_is_div;
    logic [c_CW-1:0] r_cnt;
    logic [M-1:0]    r_hi;     // MUL: upper product half; DIV: remainder
    logic [M-1:0]    r_lo;     // MUL: multiplier/low product; DIV: dividend/quotient
    logic [M-1:0]    r_opnd;   // MUL: multiplicand; DIV: divisor

    logic [M:0]      w_mul_sum;
    logic [M:0]      w_div_rem;
    logic [M:0]      w_div_sub;
    logic            w_div_ge;
    logic [M-1:0]    w_hi_nxt;
    logic [M-1:0]    w_lo_nxt;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    // Remainder shifted left by one with the next dividend bit brought in;
    // it can reach 2*divisor-1, hence the extra bit.
    assign w_div_rem = {r_hi, r_lo[M-1]};
    assign w_div_ge  = (w_div_rem >= {1'b0, r_opnd});
    assign w_div_sub = w_div_rem - {1'b0, r_opnd};

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_is_div) begin
            w_hi_nxt = w_div_ge ? w_div_sub[M-1:0] : w_div_rem[M-1:0];
            w_lo_nxt = {r_lo[M-2:0], w_div_ge};
        end else begin
            // {carry, sum, multiplier} shifted right by one
            w_hi_nxt = w_mul_sum[M:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[M-1:1]};
        end
    end

    assign o_done   = r_busy && (r_cnt == c_LAST);
    assign o_result = w_lo_nxt;
    assign o_ovf    = !r_is_div && (|w_hi_nxt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_is_div <= i_is_div;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= i_is_div ? i_a : i_b;
            r_opnd   <= i_is_div ? i_b : i_a;
        end else if (r_busy) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exe_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : exe_unit_seq
//  Purpose  : Handshaked execution unit. Accepts {oper, argA, argB}, produces
//             an M-bit result plus BF0/BF1/PF/NF flags and holds them until
//             the consumer takes them. Logic/add/shift ops finish in one
//             cycle; MUL/DIV run M cycles in exe_iter_muldiv.
//  Ports    : i_clk, i_rst_n           clock, async active-low reset
//             i_req_valid/o_req_ready  request handshake
//             i_oper, i_argA, i_argB   opcode and unsigned operands
//             o_res_valid/i_res_ready  response handshake
//             o_result                 result
//             o_BF0 zero, o_BF1 exception, o_PF even parity, o_NF msb
//  Revision : 1.0  initial release
// ============================================================================
module exe_unit_seq
    import exe_seq_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [N-1:0] i_oper,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    output logic         o_res_valid,
    input  logic         i_res_ready,
    output logic [M-1:0] o_result,
    output logic         o_BF0,
    output logic         o_BF1,
    output logic         o_PF,
    output logic         o_NF
);

    localparam int c_SW = $clog2(M);

    state_e                r_state;
    logic                  r_res_valid;
    logic [M-1:0]          r_result;
    logic [c_FLAG_W-1:0]   r_flags;

    logic [3:0]            w_op;
    logic                  w_accept;
    logic                  w_start_iter;
    logic [M:0]            w_add;
    logic [M:0]            w_sub;
    logic [c_SW-1:0]       w_shamt;
    logic [M-1:0]          w_alu_res;
    logic                  w_alu_exc;
    logic                  w_iter_done;
    logic [M-1:0]          w_iter_res;
    logic                  w_iter_ovf;

    function automatic logic [c_FLAG_W-1:0] f_flags(input logic [M-1:0] res,
                                                    input logic         exc);
        logic [c_FLAG_W-1:0] f;
        f             = '0;
        f[c_FLAG_BF0] = (res == '0);
        f[c_FLAG_BF1] = exc;
        f[c_FLAG_PF]  = ~(^res);
        f[c_FLAG_NF]  = res[M-1];
        return f;
    endfunction

    // Fixed encoding occupies the low four opcode bits.
    assign w_op        = i_oper[3:0];
    assign o_req_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_res_ready);
    assign w_accept    = i_req_valid && o_req_ready;
    // DIV by zero is answered by the single-cycle path, skipping BUSY.
    assign w_start_iter = w_accept &&
                          ((w_op == OP_MUL) || ((w_op == OP_DIV) && (i_argB != '0)));

    assign w_add   = {1'b0, i_argA} + {1'b0, i_argB};
    assign w_sub   = {1'b0, i_argA} - {1'b0, i_argB};
    assign w_shamt = i_argB[c_SW-1:0];

    always_comb begin
        w_alu_res = '0;
        w_alu_exc = 1'b0;
        case (w_op)
            OP_ADD: begin w_alu_res = w_add[M-1:0]; w_alu_exc = w_add[M]; end
            OP_SUB: begin w_alu_res = w_sub[M-1:0]; w_alu_exc = w_sub[M]; end
            OP_AND: w_alu_res = i_argA & i_argB;
            OP_OR:  w_alu_res = i_argA | i_argB;
            OP_XOR: w_alu_res = i_argA ^ i_argB;
            OP_NOT: w_alu_res = ~i_argA;
            OP_SHL: w_alu_res = i_argA << w_shamt;
            OP_SHR: w_alu_res = i_argA >> w_shamt;
            OP_MUL: w_alu_res = '0;
            // Only reached with B == 0; non-zero divisors go iterative.
            OP_DIV: begin w_alu_res = '1; w_alu_exc = 1'b1; end
            default: begin w_alu_res = '0; w_alu_exc = 1'b1; end
        endcase
    end

    exe_iter_muldiv #(
        .M (M)
    ) u_iter (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_start_iter),
        .i_is_div (w_op == OP_DIV),
        .i_a      (i_argA),
        .i_b      (i_argB),
        .o_done   (w_iter_done),
        .o_result (w_iter_res),
        .o_ovf    (w_iter_ovf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_res_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_start_iter) begin
                            r_state     <= ST_BUSY;
                            r_res_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                            r_result    <= w_alu_res;
                            r_flags     <= f_flags(w_alu_res, w_alu_exc);
                        end
                    end else if ((r_state == ST_DONE) && i_res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (w_iter_done) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                        r_result    <= w_iter_res;
                        r_flags     <= f_flags(w_iter_res, w_iter_ovf);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_result    = r_result;
    assign o_BF0       = r_flags[c_FLAG_BF0];
    assign o_BF1       = r_flags[c_FLAG_BF1];
    assign o_PF        = r_flags[c_FLAG_PF];
    assign o_NF        = r_flags[c_FLAG_NF];

endmodule
`default_nettype wire
